// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with pending scoreboard and bulk-clear engine
module regfile_param #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              pend_set,
  input  logic [AW-1:0]     pend_addr,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [AW:0]   NREGS_X = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic              wr_ok, pend_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NREGS_X;
  endfunction

  // Register 0 is excluded from writes and pending only when it is hardwired.
  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_R0 && (a == '0);
  endfunction

  always_comb begin
    wr_ok   = wr_en && !clr_busy_q && in_range(wr_addr) && !is_zero_reg(wr_addr);
    pend_ok = pend_set && !clr_busy_q && in_range(pend_addr) && !is_zero_reg(pend_addr);
  end

  always_comb begin
    rd_data_a = '0;
    if (in_range(rd_addr_a) && !is_zero_reg(rd_addr_a)) begin
      if (BYPASS && wr_ok && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      else                                          rd_data_a = regs_q[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (in_range(rd_addr_b) && !is_zero_reg(rd_addr_b)) begin
      if (BYPASS && wr_ok && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      else                                          rd_data_b = regs_q[rd_addr_b];
    end
  end

  always_comb begin
    pend_a = in_range(rd_addr_a) ? pend_q[rd_addr_a] : 1'b0;
    pend_b = in_range(rd_addr_b) ? pend_q[rd_addr_b] : 1'b0;
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    regs_d     = regs_q;
    pend_d     = pend_q;

    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    // Applied after the clear so a newly issued producer wins.
    if (pend_ok) pend_d[pend_addr] = 1'b1;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clr_busy_d = 1'b1;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        pend_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d    = DONE;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      regs_q     <= '{default: '0};
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      regs_q     <= regs_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed bench for regfile_param across several parameter sets
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Shared stimulus for the two 32x8 instances (bypass on / off)
  logic        wr_en = 0, pend_set = 0, clr_start = 0;
  logic [2:0]  wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0, pend_addr = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] a_rd_a, a_rd_b, b_rd_a, b_rd_b;
  logic        a_pa, a_pb, a_busy, a_done, b_pa, b_pb, b_busy, b_done;

  // 16x12 instance with a writable r0
  logic        d_wr_en = 0, d_pend_set = 0, d_clr_start = 0;
  logic [3:0]  d_wr_addr = 0, d_rd_addr_a = 0, d_rd_addr_b = 0, d_pend_addr = 0;
  logic [15:0] d_wr_data = 0;
  logic [15:0] d_rd_a, d_rd_b;
  logic        d_pa, d_pb, d_busy, d_done;

  int busy_cycles, done_count, done_cycle;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(32), .NREGS(8), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_a (
    .clk(clk), .resetn(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(a_rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(a_rd_b),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(a_pa), .pend_b(a_pb),
    .clr_start(clr_start), .clr_busy(a_busy), .clr_done(a_done));

  regfile_param #(.DATA_W(32), .NREGS(8), .ZERO_R0(1'b1), .BYPASS(1'b0)) u_b (
    .clk(clk), .resetn(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(b_rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(b_rd_b),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(b_pa), .pend_b(b_pb),
    .clr_start(clr_start), .clr_busy(b_busy), .clr_done(b_done));

  regfile_param #(.DATA_W(16), .NREGS(12), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_d (
    .clk(clk), .resetn(rst), .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
    .rd_addr_a(d_rd_addr_a), .rd_data_a(d_rd_a), .rd_addr_b(d_rd_addr_b), .rd_data_b(d_rd_b),
    .pend_set(d_pend_set), .pend_addr(d_pend_addr), .pend_a(d_pa), .pend_b(d_pb),
    .clr_start(d_clr_start), .clr_busy(d_busy), .clr_done(d_done));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ad, input logic [31:0] dt);
    wr_en = 1'b1; wr_addr = ad; wr_data = dt;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_pend_a", 32'(a_pa), 32'd0);

    // Asynchronous reset between edges wipes stored data immediately
    wr(3'd5, 32'h0000_0055);
    rd_addr_b = 3'd5;
    #1 chk("pre_rst_r5", a_rd_b, 32'h0000_0055);
    #2 rst = 1'b1;
    #1 chk("async_rst_r5", a_rd_b, 32'h0);
    tick();
    rst = 1'b0;

    wr(3'd0, 32'hDEAD_BEEF);
    wr(3'd5, 32'hDEAD_BEEF);
    rd_addr_a = 3'd0; rd_addr_b = 3'd5;
    #1;
    chk("r0_zero", a_rd_a, 32'h0);
    chk("r5_data", a_rd_b, 32'hDEAD_BEEF);
    chk("pend_a_clear", 32'(a_pa), 32'd0);
    chk("pend_b_clear", 32'(a_pb), 32'd0);

    // Bypass versus registered visibility
    rd_addr_a = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'h1234_5678;
    #1;
    chk("bypass_on", a_rd_a, 32'h1234_5678);
    chk("bypass_off_old", b_rd_a, 32'h0);
    tick();
    wr_en = 1'b0;
    #1 chk("bypass_off_new", b_rd_a, 32'h1234_5678);
    rd_addr_a = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFFF;
    #1 chk("bypass_r0", a_rd_a, 32'h0);
    tick();
    wr_en = 1'b0;

    // Scoreboard
    rd_addr_a = 3'd3;
    pend_set = 1'b1; pend_addr = 3'd3;
    tick();
    pend_set = 1'b0;
    #1 chk("pend_set_r3", 32'(a_pa), 32'd1);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h33; pend_set = 1'b1; pend_addr = 3'd3;
    tick();
    wr_en = 1'b0; pend_set = 1'b0;
    #1;
    chk("pend_set_wins", 32'(a_pa), 32'd1);
    chk("r3_written", a_rd_a, 32'h33);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h34;
    #1 chk("pend_no_bypass", 32'(a_pa), 32'd1);
    tick();
    wr_en = 1'b0;
    #1 chk("pend_cleared", 32'(a_pa), 32'd0);
    rd_addr_b = 3'd0;
    pend_set = 1'b1; pend_addr = 3'd0;
    tick();
    pend_set = 1'b0;
    #1 chk("pend_r0_ignored", 32'(a_pb), 32'd0);

    // Bulk clear
    for (int i = 1; i < 8; i++) wr(3'(i), 32'(i * 17));
    pend_set = 1'b1; pend_addr = 3'd6;
    tick();
    pend_set = 1'b0;
    clr_start = 1'b1;
    busy_cycles = 0; done_count = 0; done_cycle = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (a_busy) busy_cycles++;
      if (a_done) begin done_count++; done_cycle = c; end
      if (c == 1) clr_start = 1'b0;
      if (c == 2) begin
        rd_addr_a = 3'd1;
        #1 chk("clear_keeps_r1", a_rd_a, 32'h11);
      end
      if (c == 4) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hFF; end
      if (c == 5) wr_en = 1'b0;
    end
    chk("busy_cycles", 32'(busy_cycles), 32'd8);
    chk("done_count", 32'(done_count), 32'd1);
    chk("done_cycle", 32'(done_cycle), 32'd9);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1 chk($sformatf("cleared_r%0d", i), a_rd_a, 32'h0);
    end
    rd_addr_a = 3'd6;
    #1 chk("clear_pend_r6", 32'(a_pa), 32'd0);

    // Reset during the third CLEAR cycle
    wr(3'd4, 32'h44);
    rd_addr_a = 3'd4;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick(); tick();
    chk("midclr_busy_before", 32'(a_busy), 32'd1);
    chk("midclr_r4_before", a_rd_a, 32'h44);
    rst = 1'b1;
    #1;
    chk("midclr_busy_after", 32'(a_busy), 32'd0);
    chk("midclr_r4_after", a_rd_a, 32'h0);
    tick(); tick();
    rst = 1'b0;
    done_count = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (a_done) done_count++;
    end
    chk("midclr_no_done", 32'(done_count), 32'd0);

    // 16-bit, 12-register instance without hardwired r0
    d_wr_en = 1'b1; d_wr_addr = 4'd0; d_wr_data = 16'hABCD;
    tick();
    d_wr_addr = 4'd11; d_wr_data = 16'h1111;
    tick();
    d_wr_en = 1'b0;
    d_rd_addr_a = 4'd0; d_rd_addr_b = 4'd11;
    #1;
    chk("d_r0_writable", 32'(d_rd_a), 32'h0000_ABCD);
    chk("d_r11", 32'(d_rd_b), 32'h0000_1111);
    d_rd_addr_b = 4'd13;
    d_wr_en = 1'b1; d_wr_addr = 4'd13; d_wr_data = 16'h5555;
    #1 chk("d_oob_no_bypass", 32'(d_rd_b), 32'h0);
    tick();
    d_wr_en = 1'b0;
    #1 chk("d_oob_read", 32'(d_rd_b), 32'h0);
    d_pend_set = 1'b1; d_pend_addr = 4'd13;
    tick();
    d_pend_addr = 4'd0;
    #1 chk("d_oob_pend", 32'(d_pb), 32'd0);
    tick();
    d_pend_set = 1'b0;
    #1 chk("d_r0_pend", 32'(d_pa), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the fixed 32x32 register array.
- Configurable register width and count, two combinational read ports and one write port with optional write-to-read bypass.
- Hardwired-zero r0 option, a per-register pending (scoreboard) bit array, and a sequential bulk-clear engine with a busy/done handshake.
- Sits between the processor control FSM and the datapath and replaces the discrete per-register instances.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of registers; must be ≥2. Address width AW = clog2(NREGS), derived, not overridable.
- ZERO_R0, 1, 1 = register 0 always reads 0, ignores writes, and is never pending.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous reset, active-high (1 = reset), despite the name.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write register index.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  AW  read port A index.
- rd_data_a  out  DATA_W  read port A data (combinational).
- rd_addr_b  in  AW  read port B index.
- rd_data_b  out  DATA_W  read port B data (combinational).
- pend_set  in  1  mark register pend_addr as awaiting a result.
- pend_addr  in  AW  register to mark pending.
- pend_a  out  1  pending bit of rd_addr_a (combinational).
- pend_b  out  1  pending bit of rd_addr_b (combinational).
- clr_start  in  1  request bulk clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (asynchronous, resetn=1):
  - All registers = 0 and all pending bits = 0.
  - FSM = IDLE, clr_busy = 0, clr_done = 0.
  - Takes effect immediately, including mid-clear (the clear is aborted, no done pulse).
- Write:
  - On posedge clk, if wr_en=1, state is IDLE, and wr_addr < NREGS, then reg[wr_addr] <= wr_data.
  - Ignored when wr_addr ≥ NREGS, when wr_addr = 0 with ZERO_R0 = 1, or when clr_busy = 1.
- Read:
  - rd_data_x = reg[rd_addr_x], combinational.
  - rd_addr_x ≥ NREGS reads 0.
  - With ZERO_R0 = 1, address 0 reads 0.
- Bypass (BYPASS = 1 only):
  - If a write would be accepted this cycle and wr_addr == rd_addr_x, rd_data_x = wr_data in the same cycle.
  - Never applies to r0 when ZERO_R0 = 1, and never applies while clr_busy = 1.
  - With BYPASS = 0, the new value is visible the cycle after the edge.
- Pending bits:
  - An accepted write clears pend[wr_addr] at the edge.
  - pend_set = 1 in IDLE sets pend[pend_addr] at the edge.
  - Set and clear on the same address in the same cycle: set wins (a new producer has been issued).
  - pend_set is ignored for out-of-range addresses, for address 0 when ZERO_R0 = 1, and while clr_busy = 1.
  - pend_a/pend_b reflect registered state only; no bypass, so a clearing write is visible the next cycle.
  - Out-of-range read addresses report pending = 0.
- Clear FSM, states IDLE → CLEAR → DONE → IDLE:
  - IDLE: clr_start = 1 → CLEAR, cnt <= 0, clr_busy = 1 from the next cycle.
  - CLEAR: each cycle, reg[cnt] <= 0 and pend[cnt] <= 0, then cnt <= cnt + 1. When cnt == NREGS-1, go to DONE.
  - DONE: clr_done = 1 and clr_busy = 0 for exactly one cycle, then → IDLE. Writes and pend_set are accepted again in this cycle.
  - clr_start is ignored outside IDLE.
  - The clear occupies exactly NREGS cycles of clr_busy = 1. clr_done is asserted on cycle NREGS+1 after the start edge.
  - Reads during CLEAR return the current stored contents; registers not yet cleared keep their old values.
- clr_start and wr_en in the same IDLE cycle: the write is performed at that edge; the clear starts at the same edge and later zeroes that register.

Test Plan:
- Reset and r0: assert resetn mid-run, then write 0xDEADBEEF to r0 and r5 → r0 reads 0, r5 reads 0xDEADBEEF the next cycle; pend_a = pend_b = 0 after reset.
- Bypass: BYPASS = 1, wr_en = 1, wr_addr = 7, wr_data = 0x12345678, rd_addr_a = 7 → rd_data_a = 0x12345678 in the same cycle. Repeat with BYPASS = 0 → old value, then 0x12345678 after the edge.
- Scoreboard: pend_set on r3 → pend_a(3) = 1. The following cycle, write r3 with pend_set r3 → pend stays 1. Write r3 alone → pend = 0 the next cycle.
- Bulk clear, NREGS = 8: fill r1..r7 with 0x11..0x77, pulse clr_start → clr_busy high for 8 cycles, clr_done pulses once on cycle 9, and all registers read 0. wr_en to r2 during busy leaves r2 = 0.
- Reset mid-clear: assert resetn on the 3rd CLEAR cycle → clr_busy = 0 and all registers 0 immediately, with no clr_done pulse.
- Parametrisation: DATA_W = 16, NREGS = 12, ZERO_R0 = 0 → r0 writable (0xABCD read back); a write to address 13 is ignored and reads of address 13 return 0.
